// File: rtl/pcap_capture_arb_if.sv
// pcap_capture_arb_if: AXI-Stream capture taps in, merged AXI-Stream out.
// The arbiter connects through the slave modport; the traffic side uses master.
interface pcap_capture_arb_if #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
);
  logic [NUM_PORTS*DATA_WIDTH-1:0] s_tdata;
  logic [NUM_PORTS*KEEP_WIDTH-1:0] s_tkeep;
  logic [NUM_PORTS-1:0]            s_tvalid;
  logic [NUM_PORTS-1:0]            s_tlast;
  logic [NUM_PORTS-1:0]            s_tready;
  logic [DATA_WIDTH-1:0]           m_tdata;
  logic [KEEP_WIDTH-1:0]           m_tkeep;
  logic                            m_tvalid;
  logic                            m_tlast;
  logic [ID_WIDTH-1:0]             m_tid;
  logic                            m_tready;

  modport slave (
    input  s_tdata, s_tkeep, s_tvalid, s_tlast, m_tready,
    output s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast, m_tid
  );

  modport master (
    output s_tdata, s_tkeep, s_tvalid, s_tlast, m_tready,
    input  s_tready, m_tdata, m_tkeep, m_tvalid, m_tlast, m_tid
  );
endinterface

// File: rtl/pcap_capture_arb.sv
// pcap_capture_arb: packet-granular round-robin merge of capture taps into one stream.
// Define PCAP_ARB_PRIO_EN to give port 0 strict priority over the round-robin ports.
module pcap_capture_arb #(
  parameter int NUM_PORTS  = 4,
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int ID_WIDTH   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                    clk_in,
  input  logic                    reset_n,
  pcap_capture_arb_if.slave       bus,
  output logic                    busy,
  output logic [NUM_PORTS*16-1:0] pkt_count
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t                state;
  logic [ID_WIDTH-1:0]   grant;
  logic [ID_WIDTH-1:0]   rr_ptr;
  logic [ID_WIDTH-1:0]   next_rr;
  logic [ID_WIDTH-1:0]   pick;
  logic [ID_WIDTH-1:0]   scan_idx;
  logic                  pick_valid;

  logic [DATA_WIDTH-1:0] out_data;
  logic [KEEP_WIDTH-1:0] out_keep;
  logic                  out_valid;
  logic                  out_last;
  logic [ID_WIDTH-1:0]   out_tid;

  logic                  sel_valid;
  logic                  sel_last;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [KEEP_WIDTH-1:0] sel_keep;
  logic [NUM_PORTS-1:0]  ready_vec;
  logic                  out_free;
  logic                  accept;

  // First requesting port at or after rr_ptr, wrapping around the taps.
  always_comb begin
    pick       = '0;
    pick_valid = 1'b0;
    scan_idx   = '0;
`ifdef PCAP_ARB_PRIO_EN
    if (bus.s_tvalid[0]) begin
      pick_valid = 1'b1;
    end
`endif
    for (int i = 0; i < NUM_PORTS; i++) begin
      scan_idx = ID_WIDTH'((int'(rr_ptr) + i) % NUM_PORTS);
      if (!pick_valid && bus.s_tvalid[scan_idx]) begin
        pick       = scan_idx;
        pick_valid = 1'b1;
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_keep  = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (grant == ID_WIDTH'(p)) begin
        sel_valid = bus.s_tvalid[p];
        sel_last  = bus.s_tlast[p];
        sel_data  = bus.s_tdata[p*DATA_WIDTH +: DATA_WIDTH];
        sel_keep  = bus.s_tkeep[p*KEEP_WIDTH +: KEEP_WIDTH];
      end
    end
  end

  // The output register can take a beat when empty or draining this cycle.
  assign out_free = ~out_valid | bus.m_tready;
  assign accept   = (state == GRANT) && sel_valid && out_free;
  assign next_rr  = (grant == ID_WIDTH'(NUM_PORTS - 1)) ? '0 : grant + ID_WIDTH'(1);

  always_comb begin
    ready_vec = '0;
    if (state == GRANT) begin
      for (int p = 0; p < NUM_PORTS; p++) begin
        if (grant == ID_WIDTH'(p)) begin
          ready_vec[p] = out_free;
        end
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (!reset_n) begin
      state     <= IDLE;
      grant     <= '0;
      rr_ptr    <= '0;
      out_data  <= '0;
      out_keep  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_tid   <= '0;
      pkt_count <= '0;
    end else begin
      if (accept) begin
        out_data  <= sel_data;
        out_keep  <= sel_keep;
        out_last  <= sel_last;
        out_tid   <= grant;
        out_valid <= 1'b1;
      end else if (bus.m_tready) begin
        out_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (pick_valid) begin
            grant <= pick;
            state <= GRANT;
          end
        end
        GRANT: begin
          if (accept && sel_last) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
              if (grant == ID_WIDTH'(p)) begin
                pkt_count[p*16 +: 16] <= pkt_count[p*16 +: 16] + 16'd1;
              end
            end
`ifdef PCAP_ARB_PRIO_EN
            // Port 0 sits outside the rotation, so its packets leave rr_ptr alone.
            if (grant != '0) begin
              rr_ptr <= next_rr;
            end
`else
            rr_ptr <= next_rr;
`endif
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.s_tready = ready_vec;
  assign bus.m_tdata  = out_data;
  assign bus.m_tkeep  = out_keep;
  assign bus.m_tvalid = out_valid;
  assign bus.m_tlast  = out_last;
  assign bus.m_tid    = out_tid;
  assign busy         = (state == GRANT);

endmodule

// File: tb/tb_pcap_capture_arb.sv
// tb_pcap_capture_arb: random and directed traffic into pcap_capture_arb, checked
// every cycle against a packet-level arbitration model kept in the bench.
module tb_pcap_capture_arb;
  localparam int NP = 4;
  localparam int DW = 64;
  localparam int KW = 8;
  localparam int IW = 2;

  typedef struct {
    logic [DW-1:0] data;
    logic [KW-1:0] keep;
    logic          last;
  } beat_t;

  logic             clk_in = 1'b0;
  logic             reset_n = 1'b0;
  logic             busy;
  logic [NP*16-1:0] pkt_count;

  pcap_capture_arb_if #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW)) bus ();

  pcap_capture_arb #(.NUM_PORTS(NP), .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(IW)) dut (
    .clk_in   (clk_in),
    .reset_n  (reset_n),
    .bus      (bus),
    .busy     (busy),
    .pkt_count(pkt_count)
  );

  always #5 clk_in = ~clk_in;

  beat_t src_q[NP][$];
  bit    present[NP];
  int    pushed[NP];
  beat_t last_pushed[$];

  int    mdl_owner = -1;
  int    mdl_rr = 0;
  bit    mdl_ov = 1'b0;
  beat_t mdl_out;
  int    mdl_tid = 0;
  int    mdl_cnt[NP];
  bit    mdl_acc[NP];
  int    pkt_log[$];
  beat_t delivered[$];
  int    dlv_tid[$];

  int errors = 0;
  int checks = 0;

  task automatic check_val(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int pick_port(logic [NP-1:0] v);
`ifdef PCAP_ARB_PRIO_EN
    if (v[0]) return 0;
`endif
    for (int i = 0; i < NP; i++) begin
      if (v[IW'((mdl_rr + i) % NP)]) return (mdl_rr + i) % NP;
    end
    return -1;
  endfunction

  // Packet-level reference: one owner at a time, one arbitration cycle between packets.
  always @(posedge clk_in) begin
    bit    free;
    bit    acc;
    int    o;
    int    p;
    beat_t b;
    for (int i = 0; i < NP; i++) mdl_acc[i] = 1'b0;
    if (!reset_n) begin
      mdl_owner = -1;
      mdl_rr = 0;
      mdl_ov = 1'b0;
      mdl_out.data = '0;
      mdl_out.keep = '0;
      mdl_out.last = 1'b0;
      mdl_tid = 0;
      for (int i = 0; i < NP; i++) mdl_cnt[i] = 0;
    end else begin
      free = !mdl_ov || bus.m_tready;
      if (mdl_ov && bus.m_tready) begin
        delivered.push_back(mdl_out);
        dlv_tid.push_back(mdl_tid);
      end
      acc = (mdl_owner >= 0) && bus.s_tvalid[IW'(mdl_owner)] && free;
      if (acc) begin
        o = mdl_owner;
        b = src_q[o].pop_front();
        mdl_out = b;
        mdl_tid = o;
        mdl_ov = 1'b1;
        mdl_acc[o] = 1'b1;
        if (b.last) begin
          mdl_cnt[o] = (mdl_cnt[o] + 1) % 65536;
          pkt_log.push_back(o);
`ifdef PCAP_ARB_PRIO_EN
          if (o != 0) mdl_rr = (o + 1) % NP;
`else
          mdl_rr = (o + 1) % NP;
`endif
          mdl_owner = -1;
        end
      end else begin
        if (bus.m_tready) mdl_ov = 1'b0;
        if (mdl_owner < 0) begin
          p = pick_port(bus.s_tvalid);
          if (p >= 0) mdl_owner = p;
        end
      end
    end
  end

  task automatic checkOutput();
    logic [NP-1:0]    exp_rdy;
    logic [NP*16-1:0] exp_cnt;
    exp_rdy = '0;
    if (mdl_owner >= 0 && (!mdl_ov || bus.m_tready)) exp_rdy[IW'(mdl_owner)] = 1'b1;
    for (int p = 0; p < NP; p++) exp_cnt[p*16 +: 16] = 16'(mdl_cnt[p]);
    check_val("s_tready", 64'(bus.s_tready), 64'(exp_rdy));
    check_val("busy", 64'(busy), 64'(mdl_owner >= 0));
    check_val("m_tvalid", 64'(bus.m_tvalid), 64'(mdl_ov));
    check_val("m_tlast", 64'(bus.m_tlast), 64'(mdl_out.last));
    check_val("m_tid", 64'(bus.m_tid), 64'(mdl_tid));
    check_val("m_tdata", 64'(bus.m_tdata), 64'(mdl_out.data));
    check_val("m_tkeep", 64'(bus.m_tkeep), 64'(mdl_out.keep));
    check_val("pkt_count", 64'(pkt_count), 64'(exp_cnt));
  endtask

  always @(posedge clk_in) begin
    #1;
    checkOutput();
  end

  task automatic applyStimulus(int ready_pct, int present_pct);
    logic [NP*DW-1:0] d;
    logic [NP*KW-1:0] k;
    logic [NP-1:0]    v;
    logic [NP-1:0]    l;
    d = '0; k = '0; v = '0; l = '0;
    for (int p = 0; p < NP; p++) begin
      if (mdl_acc[p]) present[p] = 1'b0;
      if (!present[p] && src_q[p].size() > 0 && int'($urandom_range(99)) < present_pct)
        present[p] = 1'b1;
      if (present[p]) begin
        d[p*DW +: DW] = src_q[p][0].data;
        k[p*KW +: KW] = src_q[p][0].keep;
        l[p] = src_q[p][0].last;
        v[p] = 1'b1;
      end
    end
    bus.s_tdata  = d;
    bus.s_tkeep  = k;
    bus.s_tlast  = l;
    bus.s_tvalid = v;
    bus.m_tready = (int'($urandom_range(99)) < ready_pct);
  endtask

  task automatic run_cycles(int n, int ready_pct, int present_pct);
    repeat (n) begin
      @(negedge clk_in);
      applyStimulus(ready_pct, present_pct);
    end
  endtask

  task automatic do_reset(int n, bit all_valid);
    @(negedge clk_in);
    reset_n = 1'b0;
    for (int p = 0; p < NP; p++) begin
      src_q[p].delete();
      present[p] = 1'b0;
      pushed[p] = 0;
    end
    bus.s_tdata  = '0;
    bus.s_tkeep  = '0;
    bus.s_tlast  = '0;
    bus.s_tvalid = all_valid ? '1 : '0;
    bus.m_tready = 1'b1;
    repeat (n) @(negedge clk_in);
    reset_n = 1'b1;
    bus.s_tvalid = '0;
  endtask

  task automatic push_packet(int port, int len, logic [KW-1:0] last_keep);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.data = {$urandom, $urandom};
      b.keep = (i == len - 1) ? last_keep : '1;
      b.last = (i == len - 1);
      src_q[port].push_back(b);
      last_pushed.push_back(b);
    end
    pushed[port]++;
  endtask

  task automatic clear_logs();
    pkt_log.delete();
    delivered.delete();
    dlv_tid.delete();
    last_pushed.delete();
  endtask

  initial begin
    int exp_order[8];
    int exp_prio[6];
    bus.s_tdata  = '0;
    bus.s_tkeep  = '0;
    bus.s_tlast  = '0;
    bus.s_tvalid = '0;
    bus.m_tready = 1'b0;

    // Reset with every tap requesting.
    do_reset(3, 1'b1);
    check_val("rst_m_tvalid", 64'(bus.m_tvalid), 64'd0);
    check_val("rst_s_tready", 64'(bus.s_tready), 64'd0);
    check_val("rst_pkt_count", 64'(pkt_count), 64'd0);
    check_val("rst_busy", 64'(busy), 64'd0);

    // One 3-beat packet on port 2.
    clear_logs();
    push_packet(2, 3, 8'hFF);
    run_cycles(10, 100, 100);
    check_val("p2_log_len", 64'(pkt_log.size()), 64'd1);
    check_val("p2_log_port", 64'(pkt_log[0]), 64'd2);
    check_val("p2_beats", 64'(delivered.size()), 64'd3);
    for (int i = 0; i < 3; i++) check_val("p2_tid", 64'(dlv_tid[i]), 64'd2);
    check_val("p2_tlast", 64'(delivered[2].last), 64'd1);
    check_val("p2_count", 64'(pkt_count[2*16 +: 16]), 64'd1);
    check_val("p2_busy", 64'(busy), 64'd0);

    // All four taps busy with two 2-beat packets each.
    do_reset(2, 1'b0);
    clear_logs();
`ifdef PCAP_ARB_PRIO_EN
    exp_order = '{0, 0, 1, 2, 3, 1, 2, 3};
`else
    exp_order = '{0, 1, 2, 3, 0, 1, 2, 3};
`endif
    for (int r = 0; r < 2; r++)
      for (int p = 0; p < NP; p++) push_packet(p, 2, 8'hFF);
    run_cycles(40, 100, 100);
    check_val("rr_log_len", 64'(pkt_log.size()), 64'd8);
    for (int i = 0; i < 8; i++) check_val("rr_order", 64'(pkt_log[i]), 64'(exp_order[i]));
    for (int p = 0; p < NP; p++) check_val("rr_count", 64'(pkt_count[p*16 +: 16]), 64'd2);

    // 5-beat packet under a randomly stalling sink.
    clear_logs();
    push_packet(1, 5, 8'h0F);
    run_cycles(40, 50, 100);
    run_cycles(10, 100, 100);
    check_val("bp_beats", 64'(delivered.size()), 64'd5);
    for (int i = 0; i < 5; i++) check_val("bp_data", 64'(delivered[i].data), 64'(last_pushed[i].data));
    check_val("bp_last_keep", 64'(bus.m_tkeep), 64'h0F);
    check_val("bp_count", 64'(pkt_count[1*16 +: 16]), 64'd3);

    // Reset lands while beat 2 of a 4-beat packet is pending.
    do_reset(1, 1'b0);
    clear_logs();
    push_packet(0, 4, 8'hFF);
    run_cycles(3, 100, 100);
    do_reset(1, 1'b0);
    check_val("mid_rst_valid", 64'(bus.m_tvalid), 64'd0);
    check_val("mid_rst_count", 64'(pkt_count), 64'd0);
    clear_logs();
    push_packet(0, 2, 8'h03);
    run_cycles(8, 100, 100);
    check_val("post_rst_count", 64'(pkt_count[0 +: 16]), 64'd1);
    check_val("post_rst_beats", 64'(delivered.size()), 64'd2);

    // Ports 0 and 1 contending with single-beat packets.
    do_reset(1, 1'b0);
    clear_logs();
`ifdef PCAP_ARB_PRIO_EN
    exp_prio = '{0, 0, 0, 0, 1, 1};
`else
    exp_prio = '{0, 1, 0, 1, 0, 0};
`endif
    for (int i = 0; i < 4; i++) push_packet(0, 1, 8'hFF);
    for (int i = 0; i < 2; i++) push_packet(1, 1, 8'hFF);
    run_cycles(20, 100, 100);
    check_val("prio_log_len", 64'(pkt_log.size()), 64'd6);
    for (int i = 0; i < 6; i++) check_val("prio_order", 64'(pkt_log[i]), 64'(exp_prio[i]));

    // Random traffic and back-pressure.
    do_reset(1, 1'b0);
    clear_logs();
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(99) < 20) begin
        int p;
        p = int'($urandom_range(NP - 1));
        if (src_q[p].size() < 8) push_packet(p, int'($urandom_range(1, 6)), KW'($urandom));
      end
      run_cycles(1, 60, 70);
    end
    run_cycles(600, 100, 100);
    for (int p = 0; p < NP; p++) begin
      check_val("rand_drained", 64'(src_q[p].size()), 64'd0);
      check_val("rand_count", 64'(pkt_count[p*16 +: 16]), 64'(pushed[p]));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
